rate_hex_counter: RTL and testbench

//  Upstream source for the 7-segment hex decoder. Produces a 4-bit value that steps
//  0..F (up or down) at a selectable rate, derived from the board clock by a rate divider.

---
 rtl/rate_hex_counter.sv | 84 ++++++++
 tb/tb_rate_hex_counter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/rate_hex_counter.sv
// Hex digit source for the 7-segment decoder: steps 0..F up or down at a rate set by a reload divider.
// Optional RATE_COUNTER_WRAP_OUT_EN adds a combinational `wrap` output for cascading digits.
module rate_hex_counter #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int DIV_W    = 28
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] speed,
  input  logic       down,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] value,
`ifdef RATE_COUNTER_WRAP_OUT_EN
  output logic       wrap,
`endif
  output logic       tick
);

  localparam logic [DIV_W-1:0] RELOAD_1HZ  = DIV_W'(CLK_FREQ - 1);
  localparam logic [DIV_W-1:0] RELOAD_2S   = DIV_W'(2 * CLK_FREQ - 1);
  localparam logic [DIV_W-1:0] RELOAD_4S   = DIV_W'(4 * CLK_FREQ - 1);

  logic [1:0]       speed_q, speed_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       value_q, value_d;
  logic             tick_c;
  logic             chg;

  function automatic logic [DIV_W-1:0] reload(input logic [1:0] s);
    case (s)
      2'b01:   reload = RELOAD_1HZ;
      2'b10:   reload = RELOAD_2S;
      2'b11:   reload = RELOAD_4S;
      default: reload = '0;
    endcase
  endfunction

  assign chg = (speed != speed_q);

  always_comb begin
    speed_d = speed;
    div_d   = div_q;
    value_d = value_q;
    tick_c  = 1'b0;
    if (load) begin
      value_d = load_val;
      div_d   = reload(speed);
    end else if (chg) begin
      // A rate change restarts the period even while frozen.
      div_d = reload(speed);
    end else if (enable) begin
      if (div_q == '0) begin
        tick_c  = 1'b1;
        div_d   = reload(speed);
        value_d = down ? (value_q - 4'd1) : (value_q + 4'd1);
      end else begin
        div_d = div_q - DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      speed_q <= 2'b00;
      div_q   <= '0;
      value_q <= 4'd0;
    end else begin
      speed_q <= speed_d;
      div_q   <= div_d;
      value_q <= value_d;
    end
  end

  // Reset clears the divider to zero, so tick must be masked while reset is held.
  assign tick  = tick_c & ~reset;
  assign value = value_q;

`ifdef RATE_COUNTER_WRAP_OUT_EN
  assign wrap = tick & (down ? (value_q == 4'h0) : (value_q == 4'hF));
`endif

endmodule

// File: tb/tb_rate_hex_counter.sv
// Scoreboard bench for rate_hex_counter with CLK_FREQ=4 (reloads 0/3/7/15).
// Stimulus pushes expected (cycle, value, wrap) per tick; a negedge monitor pops on every tick.
module tb_rate_hex_counter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [1:0] speed = 2'b00;
  logic       down = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'h0;
  logic [3:0] value;
  logic       tick;
`ifdef RATE_COUNTER_WRAP_OUT_EN
  logic       wrap;
`endif

  rate_hex_counter #(.CLK_FREQ(4), .DIV_W(8)) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .speed    (speed),
    .down     (down),
    .load     (load),
    .load_val (load_val),
    .value    (value),
`ifdef RATE_COUNTER_WRAP_OUT_EN
    .wrap     (wrap),
`endif
    .tick     (tick)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic [3:0] v;
    logic       w;
  } exp_t;

  exp_t sb[$];
  exp_t e_m;
  int total = 0;
  int bad = 0;
  int p;
  int q;

  always @(negedge clock) begin
    if (tick) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_tick: tick at cyc=%0d value=%h, required no tick", cyc, value);
      end else begin
        e_m = sb.pop_front();
        total++;
        if (cyc != e_m.c) begin
          bad++;
          $display("FAIL tick_cycle: tick at cyc=%0d, required cyc=%0d", cyc, e_m.c);
        end
        total++;
        if (value !== e_m.v) begin
          bad++;
          $display("FAIL tick_value: value=%h at tick, required %h", value, e_m.v);
        end
`ifdef RATE_COUNTER_WRAP_OUT_EN
        total++;
        if (wrap !== e_m.w) begin
          bad++;
          $display("FAIL wrap: wrap=%b at cyc=%0d, required %b", wrap, cyc, e_m.w);
        end
`endif
      end
    end
  end

  task automatic push(input int c, input logic [3:0] v, input logic w);
    exp_t e;
    e.c = c;
    e.v = v;
    e.w = w;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic to_cyc(input int c);
    while (cyc < c) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic end_test(input string name);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s_missing_ticks: %0d expected ticks not seen, required 0", name, sb.size());
    end
    sb.delete();
  endtask

  task automatic do_reset(input logic [1:0] s, input logic d);
    @(posedge clock);
    #1;
    reset = 1'b1;
    enable = 1'b1;
    load = 1'b0;
    speed = s;
    down = d;
    #1;
    chk("rst_value", value, 4'h0);
    chk("rst_tick", {3'b000, tick}, 4'h0);
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    p = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: every-cycle up count with wrap at F
    do_reset(2'b00, 1'b0);
    for (int i = 0; i <= 16; i++) push(p + i, 4'(i), (i == 15));
    to_cyc(p + 17);
    enable = 1'b0;
    #1;
    chk("t1_final", value, 4'h1);
    end_test("t1");

    // 2: 1 Hz from reset, one chg cycle then tick every 4th cycle
    do_reset(2'b01, 1'b0);
    for (int k = 0; k <= 16; k++) push(p + 4 + 4 * k, 4'(k), (k == 15));
    to_cyc(p + 69);
    enable = 1'b0;
    #1;
    chk("t2_final", value, 4'h1);
    end_test("t2");

    // 3: load in a tick cycle suppresses the step
    do_reset(2'b01, 1'b0);
    push(p + 4, 4'h0, 1'b0);
    push(p + 12, 4'hA, 1'b0);
    to_cyc(p + 8);
    load = 1'b1;
    load_val = 4'hA;
    to_cyc(p + 9);
    load = 1'b0;
    chk("t3_loaded", value, 4'hA);
    to_cyc(p + 13);
    enable = 1'b0;
    #1;
    chk("t3_after_tick", value, 4'hB);
    end_test("t3");

    // 4: down count wraps 0 -> F
    do_reset(2'b00, 1'b1);
    push(p, 4'h0, 1'b1);
    push(p + 1, 4'hF, 1'b0);
    push(p + 2, 4'hE, 1'b0);
    to_cyc(p + 3);
    enable = 1'b0;
    #1;
    chk("t4_final", value, 4'hD);
    end_test("t4");

    // 5: speed change at divider=2, then a 10-cycle freeze mid-period
    do_reset(2'b01, 1'b0);
    push(p + 28, 4'h0, 1'b0);
    to_cyc(p + 2);
    speed = 2'b11;
    to_cyc(p + 8);
    enable = 1'b0;
    to_cyc(p + 17);
    chk("t5_frozen", value, 4'h0);
    to_cyc(p + 18);
    enable = 1'b1;
    to_cyc(p + 29);
    enable = 1'b0;
    #1;
    chk("t5_final", value, 4'h1);
    end_test("t5");

    // 6: async reset mid-period at value 7, restart at 0.5 Hz
    do_reset(2'b01, 1'b0);
    for (int k = 0; k <= 6; k++) push(p + 4 + 4 * k, 4'(k), 1'b0);
    to_cyc(p + 30);
    chk("t6_before_reset", value, 4'h7);
    #1;
    reset = 1'b1;
    speed = 2'b10;
    #1;
    chk("t6_async_value", value, 4'h0);
    chk("t6_async_tick", {3'b000, tick}, 4'h0);
    to_cyc(p + 32);
    reset = 1'b0;
    q = cyc;
    push(q + 8, 4'h0, 1'b0);
    to_cyc(q + 9);
    enable = 1'b0;
    #1;
    chk("t6_final", value, 4'h1);
    end_test("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
